// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU control codes
// and the arbiter FSM state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add, sub, and, unsigned less-than; other codes give 0.
// The equality flag is produced for every control code.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [2:0]            ctrl,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  eq
);

  // Result select by control code
  always_comb begin
    sum = '0;
    case (ctrl)
      ALU_ADD:  sum = op1 + op2;
      ALU_SUB:  sum = op1 - op2;
      ALU_AND:  sum = op1 & op2;
      ALU_SLTU: sum = {{(DATA_WIDTH-1){1'b0}}, (op1 < op2)};
      default:  sum = '0;
    endcase
  end

  assign eq = (op1 == op2);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters using a round-robin
// pointer; one operation is in flight at a time (IDLE -> EXEC -> RESP).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_op1,
  input  logic [DATA_WIDTH-1:0] req0_op2,
  input  logic [2:0]            req0_ctrl,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_op1,
  input  logic [DATA_WIDTH-1:0] req1_op2,
  input  logic [2:0]            req1_ctrl,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_sum,
  output logic                  rsp_eq
);

  state_t                  state_r, state_s;
  logic                    ptr_r;
  logic [DATA_WIDTH-1:0]   op1_r, op2_r;
  logic [2:0]              ctrl_r;
  logic                    id_r;
  logic                    gnt0_s, gnt1_s;
  logic [DATA_WIDTH-1:0]   alu_sum_s;
  logic                    alu_eq_s;
  logic                    rsp_valid_r, rsp_id_r, rsp_eq_r;
  logic [DATA_WIDTH-1:0]   rsp_sum_r;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op1  (op1_r),
    .op2  (op2_r),
    .ctrl (ctrl_r),
    .sum  (alu_sum_s),
    .eq   (alu_eq_s)
  );

  // Grant and next-state; ptr_r set means requester 1 wins a tie
  always_comb begin
    gnt0_s  = 1'b0;
    gnt1_s  = 1'b0;
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!rst) begin
          gnt0_s = req0_valid && (!req1_valid || !ptr_r);
          gnt1_s = req1_valid && (!req0_valid || ptr_r);
        end else begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
        if (gnt0_s || gnt1_s) begin
          state_s = ST_EXEC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: state_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, capture, response and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= 1'b0;
      op1_r       <= '0;
      op2_r       <= '0;
      ctrl_r      <= 3'b000;
      id_r        <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_sum_r   <= '0;
      rsp_eq_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (gnt1_s) begin
            op1_r  <= req1_op1;
            op2_r  <= req1_op2;
            ctrl_r <= req1_ctrl;
            id_r   <= 1'b1;
          end else if (gnt0_s) begin
            op1_r  <= req0_op1;
            op2_r  <= req0_op2;
            ctrl_r <= req0_ctrl;
            id_r   <= 1'b0;
          end else begin
            id_r   <= id_r;
          end
        end
        ST_EXEC: begin
          rsp_sum_r   <= alu_sum_s;
          rsp_eq_r    <= alu_eq_s;
          rsp_id_r    <= id_r;
          rsp_valid_r <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            ptr_r       <= ~rsp_id_r;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: rsp_valid_r <= 1'b0;
      endcase
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_sum    = rsp_sum_r;
  assign rsp_eq     = rsp_eq_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// operations compared against a behavioural model of arbitration and ALU.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_eq;
  logic [31:0] rsp_sum;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_eq(rsp_eq)
  );

  // Reference ALU: {eq, result} from the control-code table
  function automatic logic [32:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    longint unsigned x, y, r;
    x = a;
    y = b;
    if (c == 3'd0)      r = (x + y) % 64'h1_0000_0000;
    else if (c == 3'd1) r = (x + 64'h1_0000_0000 - y) % 64'h1_0000_0000;
    else if (c == 3'd2) r = x & y;
    else if (c == 3'd5) r = (x < y) ? 64'd1 : 64'd0;
    else                r = 64'd0;
    return {(x == y), r[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    rst = 1'b0;
    ptr_m = 0;
  endtask

  // One full operation: grant check, EXEC, RESP with 'hold' stalled cycles
  task automatic run_op(input logic v0, input logic v1,
                        input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] c0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c1,
                        input int hold, input string name);
    int g;
    logic [32:0] exp;
    g = (v0 && v1) ? ptr_m : (v1 ? 1 : 0);
    exp = (g == 1) ? ref_alu(c1, a1, b1) : ref_alu(c0, a0, b0);
    req0_valid = v0; req0_op1 = a0; req0_op2 = b0; req0_ctrl = c0;
    req1_valid = v1; req1_op1 = a1; req1_op2 = b1; req1_ctrl = c1;
    rsp_ready = (hold == 0);
    @(negedge clk);
    checks++;
    if (req0_ready !== (g == 0)) begin
      errors++; $display("FAIL %s grant0: got %b want %b", name, req0_ready, (g == 0));
    end
    checks++;
    if (req1_ready !== (g == 1)) begin
      errors++; $display("FAIL %s grant1: got %b want %b", name, req1_ready, (g == 1));
    end
    tick();
    if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL %s exec: got rdy0/rdy1/rspv %b want 000", name, {req0_ready, req1_ready, rsp_valid});
    end
    tick();
    for (int i = 0; i <= hold; i++) begin
      if (i == hold) rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_eq, rsp_sum} !== {1'b1, g[0], exp}) begin
        errors++;
        $display("FAIL %s resp[%0d]: got v=%b id=%b eq=%b sum=%h want v=1 id=%0d eq=%b sum=%h",
                 name, i, rsp_valid, rsp_id, rsp_eq, rsp_sum, g, exp[32], exp[31:0]);
      end
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        errors++; $display("FAIL %s resp_rdy[%0d]: got %b want 00", name, i, {req0_ready, req1_ready});
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    ptr_m = 1 - g;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL %s rsp_done: got %b want 0", name, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op1 = 32'd1; req0_op2 = 32'd1; req0_ctrl = 3'd0;
    req1_op1 = 32'd2; req1_op2 = 32'd2; req1_ctrl = 3'd0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_eq, rsp_sum} !== 35'd0) begin
      errors++; $display("FAIL reset_rsp: got v=%b id=%b eq=%b sum=%h want all 0", rsp_valid, rsp_id, rsp_eq, rsp_sum);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    rst = 1'b0;
    ptr_m = 0;
  endtask

  task automatic test_single();
    run_op(1'b1, 1'b0, 32'd5, 32'd7, 3'b000, 32'd0, 32'd0, 3'b000, 0, "single_add");
  endtask

  task automatic test_priority();
    do_reset();
    run_op(1'b1, 1'b1, 32'd10, 32'd3, 3'b001, 32'hF0, 32'h3C, 3'b010, 0, "prio_first");
    run_op(1'b1, 1'b1, 32'd10, 32'd3, 3'b001, 32'hF0, 32'h3C, 3'b010, 0, "prio_second");
    run_op(1'b1, 1'b1, 32'd4, 32'd4, 3'b000, 32'd8, 32'd1, 3'b001, 0, "prio_third");
  endtask

  task automatic test_backpressure();
    run_op(1'b0, 1'b1, 32'd0, 32'd0, 3'b000, 32'hDEAD_0000, 32'h0000_BEEF, 3'b000, 5, "backpressure");
  endtask

  task automatic test_alu_codes();
    run_op(1'b1, 1'b0, 32'd3, 32'hFFFF_FFFF, 3'b101, 32'd0, 32'd0, 3'd0, 0, "sltu");
    run_op(1'b1, 1'b0, 32'h1234, 32'h1234, 3'b001, 32'd0, 32'd0, 3'd0, 0, "sub_eq");
    run_op(1'b0, 1'b1, 32'd0, 32'd0, 3'd0, 32'd9, 32'd9, 3'b111, 0, "code111");
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 3'b000, 32'd0, 32'd0, 3'd0, 1, "add_wrap");
  endtask

  // Offer a request, withdraw it before an edge, then confirm the pointer held
  task automatic test_drop_valid();
    req1_valid = (ptr_m == 0);
    req0_valid = (ptr_m == 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    run_op(1'b1, 1'b1, 32'd6, 32'd6, 3'b010, 32'd7, 32'd1, 3'b101, 0, "drop_valid");
  endtask

  task automatic test_reset_exec();
    run_op(1'b1, 1'b0, 32'd1, 32'd1, 3'd0, 32'd0, 32'd0, 3'd0, 0, "pre_rst");
    req1_valid = 1'b1; req1_op1 = 32'd50; req1_op2 = 32'd8; req1_ctrl = 3'd0;
    rsp_ready = 1'b1;
    tick();
    rst = 1'b1;
    req0_valid = 1'b1; req0_op1 = 32'd3; req0_op2 = 32'd4; req0_ctrl = 3'd0;
    tick();
    rst = 1'b0;
    ptr_m = 0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_sum} !== 33'd0) begin
      errors++; $display("FAIL rst_exec_rsp: got v=%b sum=%h want v=0 sum=0", rsp_valid, rsp_sum);
    end
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL rst_exec_grant: got %b want 10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL rst_exec_norsp[%0d]: got %b want 0", i, rsp_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] codes [6];
    logic v0, v1;
    logic [31:0] a0, b0, a1, b1;
    codes[0] = 3'd0; codes[1] = 3'd1; codes[2] = 3'd2;
    codes[3] = 3'd5; codes[4] = 3'd3; codes[5] = 3'd6;
    for (int n = 0; n < 30; n++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
      run_op(v0, v1, a0, b0, codes[$urandom_range(0, 5)], a1, b1, codes[$urandom_range(0, 5)],
             int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_backpressure();
    test_alu_codes();
    test_drop_valid();
    test_reset_exec();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
